// File: rtl/wbdbg_burst_bridge.sv
// Debug-core to WISHBONE master bridge: single or auto-incrementing burst
// accesses with rty retry, per-beat timeout, byte selects and cycle locking.
module wbdbg_burst_bridge #(
   parameter int ADDR_WIDTH = 21,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int ADR_INC    = 1,
   parameter int MAX_RETRY  = 3,
   parameter int TIMEOUT    = 1023
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [DATA_WIDTH-1:0]   dbg_dat_i,
   input  logic [ADDR_WIDTH-1:0]   dbg_adr_i,
   input  logic [DATA_WIDTH/8-1:0] dbg_sel_i,
   input  logic                    dbg_we_i,
   input  logic [LEN_WIDTH-1:0]    dbg_len_i,
   input  logic                    dbg_go_i,
   input  logic                    dbg_lock_i,
   output logic [DATA_WIDTH-1:0]   dbg_dat_o,
   output logic [LEN_WIDTH:0]      dbg_cnt_o,
   output logic                    dbg_busy_o,
   output logic                    dbg_done_o,
   output logic                    dbg_err_o,
   output logic                    dbg_tmo_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH/8-1:0] sel_o,
   output logic                    we_o,
   output logic                    cyc_o,
   output logic                    stb_o,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic                    ack_i,
   input  logic                    err_i,
   input  logic                    rty_i
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = LEN_WIDTH + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);
   localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(ADR_INC);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      GAP,
      HOLD
   } state_t;

   state_t                  state_q, state_d;
   logic                    go_q, go_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [SW-1:0]           sel_q, sel_d;
   logic                    we_q, we_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
   logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [RW-1:0]           retry_q, retry_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    tmo_q, tmo_d;
   logic                    cyc_q, cyc_d;
   logic                    stb_q, stb_d;
   logic                    start;

   assign start = dbg_go_i & ~go_q;

   always_comb begin
      state_d = state_q;
      go_d    = dbg_go_i;
      adr_d   = adr_q;
      sel_d   = sel_q;
      we_d    = we_q;
      len_d   = len_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      timer_d = timer_q;
      done_d  = done_q;
      err_d   = err_q;
      tmo_d   = tmo_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               adr_d   = dbg_adr_i;
               sel_d   = dbg_sel_i;
               we_d    = dbg_we_i;
               len_d   = dbg_len_i;
               wdat_d  = dbg_dat_i;
               cnt_d   = '0;
               retry_d = '0;
               timer_d = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            timer_d = timer_q + TW'(1);
            if (ack_i) begin
               cnt_d = cnt_q + CW'(1);
               if (!we_q) rdat_d = dat_i;
               if (cnt_q == {1'b0, len_q}) begin
                  done_d  = 1'b1;
                  state_d = HOLD;
               end else begin
                  adr_d   = adr_q + INC;
                  wdat_d  = dbg_dat_i;
                  retry_d = '0;
                  timer_d = '0;
                  state_d = GAP;
               end
            end else if (err_i) begin
               err_d   = 1'b1;
               state_d = HOLD;
            end else if (rty_i) begin
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + RW'(1);
                  timer_d = '0;
                  state_d = GAP;
               end else begin
                  err_d   = 1'b1;
                  state_d = HOLD;
               end
            end else if (TIMEOUT != 0 && timer_q == TMO_LAST) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = HOLD;
            end
         end
         GAP: begin
            state_d = ACCESS;
         end
         HOLD: begin
            if (!dbg_go_i) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = IDLE;
            end
         end
      endcase

      // bus outputs follow the next state so they are valid from the same edge
      stb_d  = (state_d == ACCESS);
      busy_d = (state_d == ACCESS) || (state_d == GAP);
      cyc_d  = busy_d | dbg_lock_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         go_q    <= dbg_go_i;
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         len_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         cnt_q   <= '0;
         retry_q <= '0;
         timer_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         len_q   <= len_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
      end
   end

   assign dbg_dat_o  = rdat_q;
   assign dbg_cnt_o  = cnt_q;
   assign dbg_busy_o = busy_q;
   assign dbg_done_o = done_q;
   assign dbg_err_o  = err_q;
   assign dbg_tmo_o  = tmo_q;
   assign dat_o      = wdat_q;
   assign adr_o      = adr_q;
   assign sel_o      = sel_q;
   assign we_o       = we_q;
   assign cyc_o      = cyc_q;
   assign stb_o      = stb_q;

endmodule
